// File: rtl/mult_div_unit.sv
// mult_div_unit: multicycle signed multiply / divide with HI/LO result registers.
// Ports: clk, reset (sync, active-high); a_in/b_in operands; mult_start/div_start requests;
//        hi_out/lo_out result registers; mult_done/div_done/div_zero pulses; busy.
// Latency: start seen at E0 -> done pulse after E32 (div-by-zero: after E1); new start at E33.
// Backpressure: none; starts arriving while busy are dropped, not queued.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             mult_start,
  input  logic             div_start,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             mult_done,
  output logic             div_done,
  output logic             busy,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;

  state_t           state, next_state;
  logic [CW-1:0]    cnt;
  // opnd: multiplicand magnitude (MULT) or divisor magnitude (DIV).
  // shreg: multiplier magnitude shifting out / dividend shifting out, quotient shifting in.
  // acc: upper product half (MULT) or partial remainder (DIV).
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] acc;
  logic             neg_res;   // result (product / quotient) must be negated
  logic             neg_rem;   // remainder takes dividend sign
  logic             dz;        // divisor was zero at acceptance

  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] x);
    // Magnitude of the most negative value wraps to itself, which is the
    // correct unsigned magnitude for the unsigned datapath below.
    return x[WIDTH-1] ? (~x + 1'b1) : x;
  endfunction

  // ---------------- multiply step (sign-magnitude shift-add) ----------------
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   mul_acc_nx;
  logic [WIDTH-1:0]   mul_sh_nx;
  logic [2*WIDTH-1:0] prod_mag;
  logic [2*WIDTH-1:0] prod_res;

  always_comb begin
    mul_sum    = {1'b0, acc} + ({1'b0, opnd} & {(WIDTH+1){shreg[0]}});
    mul_acc_nx = mul_sum[WIDTH:1];
    mul_sh_nx  = {mul_sum[0], shreg[WIDTH-1:1]};
    prod_mag   = {mul_acc_nx, mul_sh_nx};
    prod_res   = neg_res ? (~prod_mag + 1'b1) : prod_mag;
  end

  // ---------------- divide step (restoring on magnitudes) -------------------
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   rem_diff;
  logic             rem_ge;
  logic [WIDTH-1:0] div_acc_nx;
  logic [WIDTH-1:0] div_sh_nx;
  logic [WIDTH-1:0] quo_res;
  logic [WIDTH-1:0] rem_res;

  always_comb begin
    rem_sh     = {acc, shreg[WIDTH-1]};
    rem_diff   = rem_sh - {1'b0, opnd};
    // Partial remainder stays below the divisor, so the MSB of the
    // difference is a clean borrow flag.
    rem_ge     = ~rem_diff[WIDTH];
    div_acc_nx = rem_ge ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    div_sh_nx  = {shreg[WIDTH-2:0], rem_ge};
    quo_res    = neg_res ? (~div_sh_nx + 1'b1) : div_sh_nx;
    rem_res    = neg_rem ? (~div_acc_nx + 1'b1) : div_acc_nx;
  end

  // ---------------- FSM ------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (mult_start)     next_state = MULT;
        else if (div_start) next_state = DIV;
      end
      MULT: if (cnt == CW'(1)) next_state = DONE;
      // A zero divisor still spends one cycle in DIV so DONE is entered at E1.
      DIV:  if (dz || cnt == CW'(1)) next_state = DONE;
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // ---------------- datapath and registered outputs -------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_out    <= '0;
      lo_out    <= '0;
      mult_done <= 1'b0;
      div_done  <= 1'b0;
      div_zero  <= 1'b0;
      busy      <= 1'b0;
      cnt       <= '0;
      opnd      <= '0;
      shreg     <= '0;
      acc       <= '0;
      neg_res   <= 1'b0;
      neg_rem   <= 1'b0;
      dz        <= 1'b0;
    end else begin
      mult_done <= (state == MULT) && (next_state == DONE);
      div_done  <= (state == DIV)  && (next_state == DONE);
      div_zero  <= (state == DIV)  && (next_state == DONE) && dz;
      busy      <= (next_state != IDLE);
      case (state)
        IDLE: begin
          if (mult_start) begin
            opnd    <= abs_val(a_in);
            shreg   <= abs_val(b_in);
            acc     <= '0;
            cnt     <= CW'(WIDTH);
            neg_res <= a_in[WIDTH-1] ^ b_in[WIDTH-1];
            neg_rem <= 1'b0;
            dz      <= 1'b0;
          end else if (div_start) begin
            opnd    <= abs_val(b_in);
            shreg   <= abs_val(a_in);
            acc     <= '0;
            cnt     <= CW'(WIDTH);
            neg_res <= a_in[WIDTH-1] ^ b_in[WIDTH-1];
            neg_rem <= a_in[WIDTH-1];
            dz      <= (b_in == '0);
          end
        end
        MULT: begin
          acc   <= mul_acc_nx;
          shreg <= mul_sh_nx;
          cnt   <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            hi_out <= prod_res[2*WIDTH-1:WIDTH];
            lo_out <= prod_res[WIDTH-1:0];
          end
        end
        DIV: begin
          acc   <= div_acc_nx;
          shreg <= div_sh_nx;
          cnt   <= cnt - 1'b1;
          if (!dz && cnt == CW'(1)) begin
            hi_out <= rem_res;
            lo_out <= quo_res;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
